// File: rtl/fuzz_stim_sequencer_if.sv
// Control and stimulus bundle between the fuzz stimulus sequencer and its harness.
// The response-signature signals exist only when FUZZ_STIM_SIG_EN is defined.
interface fuzz_stim_sequencer_if #(
    parameter int IN_WIDTH  = 261,
`ifdef FUZZ_STIM_SIG_EN
    parameter int OUT_WIDTH = 330,
`endif
    parameter int CNT_W     = 32
);
    logic                 start;
    logic [31:0]          seed;
    logic [CNT_W-1:0]     num_vectors;
    logic                 hold;
    logic                 dut_rst_n;
    logic [IN_WIDTH-1:0]  stim;
    logic                 stim_valid;
    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     vec_count;
    logic [31:0]          lcg_state;
`ifdef FUZZ_STIM_SIG_EN
    logic [OUT_WIDTH-1:0] dut_out;
    logic [31:0]          signature;
`endif

    modport master (
        input  start, seed, num_vectors, hold,
        output dut_rst_n, stim, stim_valid, busy, done, vec_count, lcg_state
`ifdef FUZZ_STIM_SIG_EN
        , input dut_out, output signature
`endif
    );

    modport slave (
        output start, seed, num_vectors, hold,
        input  dut_rst_n, stim, stim_valid, busy, done, vec_count, lcg_state
`ifdef FUZZ_STIM_SIG_EN
        , output dut_out, input signature
`endif
    );
endinterface

// File: rtl/fuzz_stim_sequencer.sv
// Reset / random-vector / done sequencer driving a fuzzed DUT from a 32-bit LCG.
// Optional response signature is enabled by defining FUZZ_STIM_SIG_EN.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_DUT_RST | holding dut_rst_n low for RESET_CYCLES cycles
// S_FILL    | building the next vector one 32-bit word per cycle
// S_APPLY   | presenting the shadow vector on stim
// S_DONE    | emitting the done pulse
module fuzz_stim_sequencer #(
    parameter int          IN_WIDTH     = 261,
`ifdef FUZZ_STIM_SIG_EN
    parameter int          OUT_WIDTH    = 330,
`endif
    parameter int          RESET_CYCLES = 2,
    parameter int          CNT_W        = 32,
    parameter logic [31:0] DEFAULT_SEED = 32'd983297492
) (
    input logic                   clk,
    input logic                   rst,
    fuzz_stim_sequencer_if.master bus
);
    localparam int WORDS     = (IN_WIDTH + 31) / 32;
    localparam int LAST_BITS = IN_WIDTH - 32 * (WORDS - 1);
    localparam int KW        = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int RW        = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);
    localparam logic [RW-1:0] R_LAST = RW'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_DUT_RST, S_FILL, S_APPLY, S_DONE} state_t;

    function automatic logic [31:0] lcg_next(input logic [31:0] s);
        return s * 32'h41C6_4E6D + 32'h0000_3039;
    endfunction

    state_t              state_q, state_d;
    logic [RW-1:0]       rcnt_q, rcnt_d;
    logic [KW-1:0]       k_q, k_d;
    logic [IN_WIDTH-1:0] shadow_q, shadow_d;
    logic [IN_WIDTH-1:0] stim_q, stim_d;
    logic                stim_valid_q, stim_valid_d;
    logic                dut_rst_n_q, dut_rst_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    vec_count_q, vec_count_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [31:0]         lcg_q, lcg_d;
    logic [31:0]         lcg_step;
    logic [CNT_W-1:0]    vec_inc;

`ifdef FUZZ_STIM_SIG_EN
    localparam int SW = (OUT_WIDTH + 31) / 32;

    function automatic logic [31:0] fold32(input logic [OUT_WIDTH-1:0] v);
        logic [SW*32-1:0] padded;
        logic [31:0]      acc;
        padded              = '0;
        padded[OUT_WIDTH-1:0] = v;
        acc                 = '0;
        for (int i = 0; i < SW; i++) acc = acc ^ padded[32*i +: 32];
        return acc;
    endfunction

    logic [31:0] sig_q, sig_d;
`endif

    assign lcg_step = lcg_next(lcg_q);
    assign vec_inc  = vec_count_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        rcnt_d       = rcnt_q;
        k_d          = k_q;
        shadow_d     = shadow_q;
        stim_d       = stim_q;
        stim_valid_d = 1'b0;
        dut_rst_n_d  = dut_rst_n_q;
        done_d       = 1'b0;
        vec_count_d  = vec_count_q;
        num_d        = num_q;
        lcg_d        = lcg_q;
`ifdef FUZZ_STIM_SIG_EN
        sig_d        = sig_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    lcg_d       = bus.seed;
                    num_d       = bus.num_vectors;
                    vec_count_d = '0;
                    dut_rst_n_d = 1'b0;
                    rcnt_d      = '0;
                    state_d     = S_DUT_RST;
`ifdef FUZZ_STIM_SIG_EN
                    sig_d       = 32'hFFFF_FFFF;
`endif
                end
            end
            S_DUT_RST: begin
                // hold is deliberately ignored so the DUT reset width is fixed
                if (rcnt_q == R_LAST) begin
                    dut_rst_n_d = 1'b1;
                    k_d         = '0;
                    state_d     = (num_q == '0) ? S_DONE : S_FILL;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
            S_FILL: begin
                if (!bus.hold) begin
                    lcg_d = lcg_step;
                    for (int w = 0; w < WORDS - 1; w++) begin
                        if (k_q == KW'(w)) shadow_d[32*w +: 32] = lcg_step;
                    end
                    if (k_q == K_LAST) begin
                        shadow_d[IN_WIDTH-1:32*(WORDS-1)] = lcg_step[LAST_BITS-1:0];
                        state_d = S_APPLY;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_APPLY: begin
                if (!bus.hold) begin
                    stim_d       = shadow_q;
                    stim_valid_d = 1'b1;
                    vec_count_d  = vec_inc;
                    k_d          = '0;
                    state_d      = (vec_inc == num_q) ? S_DONE : S_FILL;
`ifdef FUZZ_STIM_SIG_EN
                    sig_d        = {sig_q[30:0], sig_q[31]} ^ fold32(bus.dut_out);
`endif
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rcnt_q       <= '0;
            k_q          <= '0;
            shadow_q     <= '0;
            stim_q       <= '0;
            stim_valid_q <= 1'b0;
            dut_rst_n_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            vec_count_q  <= '0;
            num_q        <= '0;
            lcg_q        <= DEFAULT_SEED;
`ifdef FUZZ_STIM_SIG_EN
            sig_q        <= 32'hFFFF_FFFF;
`endif
        end else begin
            state_q      <= state_d;
            rcnt_q       <= rcnt_d;
            k_q          <= k_d;
            shadow_q     <= shadow_d;
            stim_q       <= stim_d;
            stim_valid_q <= stim_valid_d;
            dut_rst_n_q  <= dut_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            vec_count_q  <= vec_count_d;
            num_q        <= num_d;
            lcg_q        <= lcg_d;
`ifdef FUZZ_STIM_SIG_EN
            sig_q        <= sig_d;
`endif
        end
    end

    assign bus.dut_rst_n  = dut_rst_n_q;
    assign bus.stim       = stim_q;
    assign bus.stim_valid = stim_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.vec_count  = vec_count_q;
    assign bus.lcg_state  = lcg_q;
`ifdef FUZZ_STIM_SIG_EN
    assign bus.signature  = sig_q;
`endif
endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
// Bench for fuzz_stim_sequencer: directed and random runs checked against an LCG vector model.
module tb_fuzz_stim_sequencer;
    localparam int          IN_W  = 261;
    localparam int          WORDS = 9;
    localparam int          RC    = 2;
    localparam logic [31:0] DSEED = 32'd983297492;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fuzz_stim_sequencer_if #(.IN_WIDTH(IN_W), .CNT_W(32)) bus ();

    fuzz_stim_sequencer #(
        .IN_WIDTH(IN_W), .RESET_CYCLES(RC), .CNT_W(32), .DEFAULT_SEED(DSEED)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    logic [IN_W-1:0] model_stim;
    logic [IN_W-1:0] first_stim;
    logic [IN_W-1:0] ev [0:15];
    logic [IN_W-1:0] h0;
    logic [31:0]     rs;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference vector: WORDS successive LCG outputs, word 0 in the low bits, truncated.
    task automatic gen_vec(inout logic [31:0] s, output logic [IN_W-1:0] v);
        logic [32*WORDS-1:0] acc;
        acc = '0;
        for (int w = 0; w < WORDS; w++) begin
            s = s * 32'h41C64E6D + 32'h3039;
            acc[32*w +: 32] = s;
        end
        v = acc[IN_W-1:0];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_stim = '0;
    endtask

    // ha/hl: hold raised at negedge ha for hl cycles; ign_at: negedge of a start pulse to ignore.
    task automatic run(input logic [31:0] sd, input int n, input int ha, input int hl,
                       input int ign_at, input string tag);
        logic [31:0] s;
        int c, got, low, exp_c, last_c;
        bit fin;
        s = sd;
        for (int v = 0; v < n; v++) gen_vec(s, ev[v]);
        bus.seed = sd; bus.num_vectors = n; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        c = 0; got = 0; low = 0; fin = 0; last_c = 0;
        chk({tag, "_busy"}, bus.busy, 1'b1);
        while (!fin && c < 400) begin
            if (!bus.dut_rst_n) low++;
            if (bus.stim_valid) begin
                exp_c = RC + WORDS + 1 + got * (WORDS + 1) + hl;
                chk({tag, "_valid_time"}, c, exp_c);
                chk({tag, "_stim"}, bus.stim, ev[got]);
                chk({tag, "_vec_count"}, bus.vec_count, got + 1);
                if (got == 0) first_stim = bus.stim;
                model_stim = ev[got];
                got++;
                last_c = c;
            end
            if (bus.done) begin
                exp_c = (n == 0) ? RC + 1 : last_c + 1;
                chk({tag, "_done_time"}, c, exp_c);
                chk({tag, "_nvec"}, got, n);
                chk({tag, "_final_count"}, bus.vec_count, n);
                chk({tag, "_final_stim"}, bus.stim, model_stim);
                chk({tag, "_final_lcg"}, bus.lcg_state, s);
                fin = 1;
            end
            bus.start = (c == ign_at);
            if (c == ign_at) begin
                bus.seed = ~sd;
                bus.num_vectors = 7;
            end
            bus.hold = (c >= ha && c < ha + hl);
            if (!fin) begin
                @(negedge clk);
                c++;
            end
        end
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        chk({tag, "_done_seen"}, fin, 1'b1);
        chk({tag, "_dut_rst_cycles"}, low, RC);
        @(negedge clk);
        chk({tag, "_done_pulse"}, bus.done, 1'b0);
        chk({tag, "_idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        bus.start = 1'b0; bus.seed = '0; bus.num_vectors = '0; bus.hold = 1'b0;
        do_reset();
        chk("rst_dut_rst_n", bus.dut_rst_n, 1'b1);
        chk("rst_stim", bus.stim, '0);
        chk("rst_stim_valid", bus.stim_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_vec_count", bus.vec_count, '0);
        chk("rst_lcg", bus.lcg_state, DSEED);

        run(32'd1, 1, -1, 0, -1, "one");
        chk("one_word0", first_stim[31:0], 32'h41C67EA6);

        run(32'd0, 2, -1, 0, -1, "two");
        chk("two_word0", first_stim[31:0], 32'h00003039);
        chk("two_word1", first_stim[63:32], 32'hD3DC167E);

        do_reset();
        run(32'h1234_5678, 0, -1, 0, 1, "zero");

        run(32'hCAFE_F00D, 1, -1, 0, -1, "nohold");
        h0 = first_stim;
        run(32'hCAFE_F00D, 1, 5, 5, -1, "hold");
        chk("hold_same_stim", first_stim, h0);

        run($urandom, 2, -1, 0, 15, "ign");
        for (int i = 0; i < 3; i++) run($urandom, $urandom_range(1, 3), -1, 0, -1, "rnd");

        rs = $urandom;
        bus.seed = rs; bus.num_vectors = 5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (25) @(negedge clk);
        chk("abort_pre_count", bus.vec_count, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_count", bus.vec_count, '0);
        chk("abort_lcg", bus.lcg_state, DSEED);
        chk("abort_dut_rst_n", bus.dut_rst_n, 1'b1);
        chk("abort_stim", bus.stim, '0);
        chk("abort_valid", bus.stim_valid, 1'b0);
        rst = 1'b0;
        model_stim = '0;
        run(rs, 1, -1, 0, -1, "rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
